// File: rtl/prio_grant_stage.sv
// Registered request collection and valid/ready grant stage over a 128-input priority encoder.
// Optional accepted-grant counter enabled by defining PRIO_GRANT_STATS_EN.
module prio_grant_stage #(
  parameter int N  = 128,
  parameter int IW = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req_set,
  input  logic          flush,
  output logic          grant_valid,
  output logic [IW-1:0] grant_idx,
  input  logic          grant_ready,
  output logic [N-1:0]  pending,
  output logic          pend_any
`ifdef PRIO_GRANT_STATS_EN
  ,
  output logic [31:0]   grant_cnt
`endif
);

  logic [N-1:0]  pend_q, pend_d;
  logic          grant_valid_q, grant_valid_d;
  logic [IW-1:0] grant_idx_q, grant_idx_d;
  logic [N-1:0]  held_mask;
  logic [N-1:0]  cand;
  logic [IW-1:0] enc_idx;
  logic          enc_any;
  logic          acc;

  assign acc       = grant_valid_q & grant_ready;
  // The presented bit stays pending until accepted, so mask it from re-selection.
  assign held_mask = grant_valid_q ? (N'(1) << grant_idx_q) : '0;
  assign cand      = pend_q & ~held_mask;

  // Ascending scan: the last hit wins, giving bit N-1 the highest priority.
  always_comb begin
    enc_idx = '0;
    enc_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (cand[i]) begin
        enc_idx = IW'(i);
        enc_any = 1'b1;
      end
    end
  end

  always_comb begin
    pend_d        = pend_q;
    grant_valid_d = grant_valid_q;
    grant_idx_d   = grant_idx_q;
    if (flush) begin
      pend_d        = '0;
      grant_valid_d = 1'b0;
    end else begin
      pend_d = (pend_q & ~(acc ? held_mask : '0)) | req_set;
      if (!grant_valid_q || acc) begin
        grant_valid_d = enc_any;
        if (enc_any) grant_idx_d = enc_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q        <= '0;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
    end else begin
      pend_q        <= pend_d;
      grant_valid_q <= grant_valid_d;
      grant_idx_q   <= grant_idx_d;
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;
  assign pending     = pend_q;
  assign pend_any    = |pend_q;

`ifdef PRIO_GRANT_STATS_EN
  logic [31:0] grant_cnt_q, grant_cnt_d;

  // Saturating; survives flush, cleared only by reset.
  always_comb begin
    grant_cnt_d = grant_cnt_q;
    if (acc && !flush && (grant_cnt_q != 32'hFFFF_FFFF)) grant_cnt_d = grant_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) grant_cnt_q <= '0;
    else        grant_cnt_q <= grant_cnt_d;
  end

  assign grant_cnt = grant_cnt_q;
`endif

endmodule
